// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory map constants and the read-owner encoding used by the
// memory arbiter and its neighbours.
package chip8_pkg;

    localparam logic [11:0] SCREEN_BASE = 12'h100;
    localparam int unsigned SCREEN_SIZE = 256;
    localparam int unsigned MEM_SIZE    = 4096;
    localparam logic [11:0] PROG_START  = 12'h200;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_VID  = 2'd2
    } rd_owner_e;

    // Window test done in 13 bits so a window near the top of memory does not wrap.
    function automatic logic in_screen_window(input logic [11:0] addr,
                                              input logic [11:0] base);
        logic [12:0] addr_ext;
        logic [12:0] base_ext;
        addr_ext = {1'b0, addr};
        base_ext = {1'b0, base};
        return (addr_ext >= base_ext) && (addr_ext < (base_ext + 13'(SCREEN_SIZE)));
    endfunction

endpackage

// File: rtl/chip8_mem_arbiter_starve_counter.sv
// Saturating 2-bit counter of consecutive denied scanout cycles; at_limit
// tells the arbiter that scanout must win the next contested slot.
module starve_counter #(
    parameter logic [1:0] LIMIT = 2'd3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [1:0] cnt_r;
    logic [1:0] cnt_next_s;

    // Next count: clear has priority, increment saturates at the top code.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = 2'd0;
        end else if (inc && (cnt_r != 2'b11)) begin
            cnt_next_s = cnt_r + 2'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 2'd0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign at_limit = (cnt_r == LIMIT);

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Single-port RAM arbiter between the CPU and the display scanout, with a
// starvation guard for scanout and a framebuffer dirty flag.
module chip8_mem_arbiter #(
    parameter logic [11:0] SCREEN_BASE  = chip8_pkg::SCREEN_BASE,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        vid_req,
    input  logic [7:0]  vid_addr,
    output logic        vid_ack,
    output logic        vid_rvalid,
    output logic [7:0]  vid_rdata,
    input  logic        vid_frame_start,
    output logic        screen_dirty,
    output logic        mem_en,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    import chip8_pkg::*;

    logic        at_limit_s;
    logic        cpu_win_s;
    logic        vid_win_s;
    logic        starve_inc_s;
    logic        starve_clr_s;
    logic [11:0] vid_mem_addr_s;
    rd_owner_e   rd_owner_r;
    rd_owner_e   rd_owner_next_s;
    logic        dirty_r;
    logic        dirty_next_s;
    logic        dirty_set_s;

    starve_counter #(
        .LIMIT (2'(STARVE_LIMIT))
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (starve_inc_s),
        .clr      (starve_clr_s),
        .at_limit (at_limit_s)
    );

    // 12-bit add wraps the scanout address modulo the memory size.
    assign vid_mem_addr_s = SCREEN_BASE + {4'h0, vid_addr};

    // Grant decision; both grants are held low while reset is asserted.
    always_comb begin
        vid_win_s = 1'b0;
        cpu_win_s = 1'b0;
        if (!rst_n) begin
            vid_win_s = 1'b0;
            cpu_win_s = 1'b0;
        end else if (vid_req && at_limit_s) begin
            vid_win_s = 1'b1;
        end else if (cpu_req) begin
            cpu_win_s = 1'b1;
        end else if (vid_req) begin
            vid_win_s = 1'b1;
        end else begin
            vid_win_s = 1'b0;
            cpu_win_s = 1'b0;
        end
    end

    assign starve_inc_s = vid_req & ~vid_win_s;
    assign starve_clr_s = ~starve_inc_s;

    // Memory port drive; address and data default to the CPU side when idle.
    always_comb begin
        mem_en    = cpu_win_s | vid_win_s;
        mem_we    = cpu_win_s & cpu_we;
        mem_wdata = cpu_wdata;
        if (vid_win_s) begin
            mem_addr = vid_mem_addr_s;
        end else begin
            mem_addr = cpu_addr;
        end
    end

    assign cpu_ack = cpu_win_s;
    assign vid_ack = vid_win_s;

    // Owner of the read whose data returns next cycle; writes produce no data.
    always_comb begin
        rd_owner_next_s = RD_NONE;
        if (cpu_win_s && !cpu_we) begin
            rd_owner_next_s = RD_CPU;
        end else if (vid_win_s) begin
            rd_owner_next_s = RD_VID;
        end else begin
            rd_owner_next_s = RD_NONE;
        end
    end

    // Read-owner register; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_r <= RD_NONE;
        end else begin
            rd_owner_r <= rd_owner_next_s;
        end
    end

    // Decode the registered owner into per-requester valid strobes.
    always_comb begin
        cpu_rvalid = 1'b0;
        vid_rvalid = 1'b0;
        case (rd_owner_r)
            RD_CPU:  cpu_rvalid = 1'b1;
            RD_VID:  vid_rvalid = 1'b1;
            RD_NONE: begin
                cpu_rvalid = 1'b0;
                vid_rvalid = 1'b0;
            end
            default: begin
                cpu_rvalid = 1'b0;
                vid_rvalid = 1'b0;
            end
        endcase
    end

    assign cpu_rdata = mem_rdata;
    assign vid_rdata = mem_rdata;

    assign dirty_set_s = cpu_win_s & cpu_we & in_screen_window(cpu_addr, SCREEN_BASE);

    // Dirty flag next state: a framebuffer write beats a same-cycle frame start.
    always_comb begin
        dirty_next_s = dirty_r;
        if (dirty_set_s) begin
            dirty_next_s = 1'b1;
        end else if (vid_frame_start) begin
            dirty_next_s = 1'b0;
        end else begin
            dirty_next_s = dirty_r;
        end
    end

    // Dirty flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_r <= 1'b0;
        end else begin
            dirty_r <= dirty_next_s;
        end
    end

    assign screen_dirty = dirty_r;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a behavioural synchronous RAM.
module tb_chip8_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        vid_req;
    logic [7:0]  vid_addr;
    logic        vid_ack, vid_rvalid;
    logic [7:0]  vid_rdata;
    logic        vid_frame_start;
    logic        screen_dirty;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        w_vid_req;
    logic [7:0]  w_vid_addr;
    logic        w_cpu_ack, w_cpu_rvalid, w_vid_ack, w_vid_rvalid, w_dirty;
    logic [7:0]  w_cpu_rdata, w_vid_rdata, w_mem_wdata;
    logic        w_mem_en, w_mem_we;
    logic [11:0] w_mem_addr;
    logic [7:0]  w_mem_rdata;

    logic [7:0]  ram [0:4095];
    logic        preload;

    int tests_run;
    int tests_failed;

    chip8_mem_arbiter u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ack         (cpu_ack),
        .cpu_rvalid      (cpu_rvalid),
        .cpu_rdata       (cpu_rdata),
        .vid_req         (vid_req),
        .vid_addr        (vid_addr),
        .vid_ack         (vid_ack),
        .vid_rvalid      (vid_rvalid),
        .vid_rdata       (vid_rdata),
        .vid_frame_start (vid_frame_start),
        .screen_dirty    (screen_dirty),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    chip8_mem_arbiter #(
        .SCREEN_BASE  (12'hF80),
        .STARVE_LIMIT (3)
    ) u_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req         (1'b0),
        .cpu_we          (1'b0),
        .cpu_addr        (12'h000),
        .cpu_wdata       (8'h00),
        .cpu_ack         (w_cpu_ack),
        .cpu_rvalid      (w_cpu_rvalid),
        .cpu_rdata       (w_cpu_rdata),
        .vid_req         (w_vid_req),
        .vid_addr        (w_vid_addr),
        .vid_ack         (w_vid_ack),
        .vid_rvalid      (w_vid_rvalid),
        .vid_rdata       (w_vid_rdata),
        .vid_frame_start (1'b0),
        .screen_dirty    (w_dirty),
        .mem_en          (w_mem_en),
        .mem_we          (w_mem_we),
        .mem_addr        (w_mem_addr),
        .mem_wdata       (w_mem_wdata),
        .mem_rdata       (w_mem_rdata)
    );

    assign w_mem_rdata = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency; preload fills the framebuffer with its index.
    always @(posedge clk) begin
        if (preload) begin
            for (int j = 0; j < 256; j++) begin
                ram[12'h100 + j] <= 8'(j);
            end
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        preload         = 1'b1;
        cpu_req         = 1'b1;
        cpu_we          = 1'b0;
        cpu_addr        = 12'h020;
        cpu_wdata       = 8'h00;
        vid_req         = 1'b1;
        vid_addr        = 8'h00;
        vid_frame_start = 1'b0;
        w_vid_req       = 1'b0;
        w_vid_addr      = 8'h00;

        // Reset state with both requesters active
        @(negedge clk);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_vid_ack", 32'(vid_ack), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
        check("rst_dirty", 32'(screen_dirty), 32'd0);
        next_cycle();
        preload = 1'b0;
        rst_n   = 1'b1;
        cpu_req = 1'b0;
        vid_req = 1'b0;
        next_cycle();

        // CPU write then read of 0x020
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'h42;
        @(negedge clk);
        check("wr_cpu_ack", 32'(cpu_ack), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", 32'(mem_addr), 32'h020);
        check("wr_vid_ack", 32'(vid_ack), 32'd0);
        next_cycle();
        cpu_we = 1'b0;
        @(negedge clk);
        check("rd_cpu_ack", 32'(cpu_ack), 32'd1);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_rdata", 32'(cpu_rdata), 32'h42);
        check("idle_mem_en", 32'(mem_en), 32'd0);
        next_cycle();

        // Contention: vid must win every fourth cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
        vid_req = 1'b1; vid_addr = 8'h05;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("starve_vid_ack_%0d", i), 32'(vid_ack), 32'((i % 4) == 3));
            check($sformatf("starve_cpu_ack_%0d", i), 32'(cpu_ack), 32'((i % 4) != 3));
            if (i > 0) begin
                check($sformatf("starve_vid_rvalid_%0d", i), 32'(vid_rvalid), 32'(((i - 1) % 4) == 3));
                check($sformatf("starve_cpu_rvalid_%0d", i), 32'(cpu_rvalid), 32'(((i - 1) % 4) != 3));
            end
            if ((i % 4) == 3) begin
                check($sformatf("starve_mem_addr_%0d", i), 32'(mem_addr), 32'h105);
            end
            next_cycle();
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        @(negedge clk);
        check("starve_last_vid_rvalid", 32'(vid_rvalid), 32'd1);
        check("starve_last_rdata", 32'(vid_rdata), 32'h05);
        next_cycle();

        // Back-to-back scanout of the whole framebuffer
        for (int k = 0; k < 256; k++) begin
            vid_req  = 1'b1;
            vid_addr = 8'(k);
            @(negedge clk);
            check($sformatf("sweep_ack_%0d", k), 32'(vid_ack), 32'd1);
            check($sformatf("sweep_addr_%0d", k), 32'(mem_addr), 32'h100 + 32'(k));
            if (k > 0) begin
                check($sformatf("sweep_rvalid_%0d", k), 32'(vid_rvalid), 32'd1);
                check($sformatf("sweep_rdata_%0d", k), 32'(vid_rdata), 32'(k - 1));
            end
            next_cycle();
        end
        vid_req = 1'b0;
        @(negedge clk);
        check("sweep_rvalid_last", 32'(vid_rvalid), 32'd1);
        check("sweep_rdata_last", 32'(vid_rdata), 32'hFF);
        check("sweep_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        next_cycle();

        // Dirty flag
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h11;
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("dirty_0x200", 32'(screen_dirty), 32'd0);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 12'h0FF;
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("dirty_0x0ff", 32'(screen_dirty), 32'd0);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 12'h1FF;
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check("dirty_0x1ff", 32'(screen_dirty), 32'd1);
        next_cycle();
        vid_frame_start = 1'b1;
        next_cycle();
        vid_frame_start = 1'b0;
        @(negedge clk);
        check("dirty_cleared", 32'(screen_dirty), 32'd0);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 12'h150; vid_frame_start = 1'b1;
        next_cycle();
        cpu_req = 1'b0; vid_frame_start = 1'b0;
        @(negedge clk);
        check("dirty_set_wins", 32'(screen_dirty), 32'd1);
        next_cycle();

        // Reset right after a CPU read ack
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
        @(negedge clk);
        check("rstrd_ack", 32'(cpu_ack), 32'd1);
        next_cycle();
        rst_n   = 1'b0;
        vid_req = 1'b1;
        @(negedge clk);
        check("rstrd_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rstrd_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rstrd_vid_ack", 32'(vid_ack), 32'd0);
        check("rstrd_mem_en", 32'(mem_en), 32'd0);
        check("rstrd_dirty", 32'(screen_dirty), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rstrd_mem_en_2", 32'(mem_en), 32'd0);
        next_cycle();
        rst_n   = 1'b1;
        cpu_req = 1'b0;
        vid_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_cpu_rvalid_%0d", i), 32'(cpu_rvalid), 32'd0);
            check($sformatf("post_rst_vid_rvalid_%0d", i), 32'(vid_rvalid), 32'd0);
            next_cycle();
        end

        // Scanout address wraps modulo 4096
        w_vid_req  = 1'b1;
        w_vid_addr = 8'h90;
        @(negedge clk);
        check("wrap_vid_ack", 32'(w_vid_ack), 32'd1);
        check("wrap_mem_addr", 32'(w_mem_addr), 32'h010);
        next_cycle();
        w_vid_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
